// File: rtl/speculative_output_channel_credit_tracker_pkg.sv
// Shared sizing constants and types for the output-channel credit tracker.
// Optional feature macro used by the top: TIA_OUTPUT_CHANNEL_STRICT_PESSIMISM_EN.
package speculative_output_channel_credit_tracker_pkg;

    localparam int TIA_NUM_OUTPUT_CHANNELS  = 4;
    localparam int TIA_OCI_WIDTH            = TIA_NUM_OUTPUT_CHANNELS;
    localparam int TIA_MAX_IN_FLIGHT        = 4;
    localparam int TIA_OUTPUT_CHANNEL_DEPTH = 4;

    localparam int TIA_IN_FLIGHT_COUNT_WIDTH = $clog2(TIA_MAX_IN_FLIGHT + 1);
    localparam int TIA_FREE_SLOTS_WIDTH      = $clog2(TIA_OUTPUT_CHANNEL_DEPTH + 1);

    typedef logic [TIA_IN_FLIGHT_COUNT_WIDTH-1:0] in_flight_count_t;
    typedef logic [TIA_FREE_SLOTS_WIDTH-1:0]      free_slots_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/speculative_output_channel_credit_tracker_counter.sv
// Saturating up/down counter of outstanding writes for a single output channel.
// One increment and two independent decrements may land in the same cycle.
module in_flight_write_counter #(
    parameter int MAX_IN_FLIGHT = 4,
    parameter int CW            = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec_a,
    input  logic          dec_b,
    output logic [CW-1:0] count,
    output logic          error
);

    // Two guard bits: one for sign, one for the +1 above the ceiling.
    localparam int AW = CW + 2;

    logic signed [AW-1:0] sum_next;
    logic        [CW-1:0] count_next;

    always_comb begin
        sum_next   = signed'({2'b00, count})
                   + signed'(AW'(inc))
                   - signed'(AW'(dec_a))
                   - signed'(AW'(dec_b));
        count_next = sum_next[CW-1:0];
        error      = 1'b0;
        if (sum_next < 0) begin
            count_next = '0;
            error      = 1'b1;
        end else if (sum_next > signed'(AW'(MAX_IN_FLIGHT))) begin
            count_next = CW'(MAX_IN_FLIGHT);
            error      = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/speculative_output_channel_credit_tracker.sv
// Per-output-channel in-flight write tracker feeding trigger resolution with credit-based full status.
// Define TIA_OUTPUT_CHANNEL_STRICT_PESSIMISM_EN to mark a channel full whenever any write is in flight.
module speculative_output_channel_credit_tracker
    import speculative_output_channel_credit_tracker_pkg::*;
#(
    parameter int NUM_CHANNELS  = TIA_NUM_OUTPUT_CHANNELS,
    parameter int MAX_IN_FLIGHT = TIA_MAX_IN_FLIGHT,
    parameter int CHANNEL_DEPTH = TIA_OUTPUT_CHANNEL_DEPTH,
    parameter int CW            = $clog2(MAX_IN_FLIGHT + 1),
    parameter int FW            = $clog2(CHANNEL_DEPTH + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic [NUM_CHANNELS-1:0]          issue_oci,
    input  logic                             retire_valid,
    input  logic [NUM_CHANNELS-1:0]          retire_oci,
    input  logic                             squash_valid,
    input  logic [NUM_CHANNELS-1:0]          squash_oci,
    input  logic [NUM_CHANNELS-1:0][FW-1:0]  output_channel_free_slots,
    output logic [NUM_CHANNELS-1:0]          updated_output_channel_full_status,
    output logic [NUM_CHANNELS-1:0][CW-1:0]  in_flight_count,
    output logic                             protocol_error
);

    localparam int CMP_W = max_int(CW, FW);

    logic [NUM_CHANNELS-1:0] counter_error;
    logic [NUM_CHANNELS-1:0] issue_while_full;
    logic                    protocol_error_next;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
            logic [CMP_W-1:0] count_ext;
            logic [CMP_W-1:0] free_ext;

            in_flight_write_counter #(
                .MAX_IN_FLIGHT (MAX_IN_FLIGHT),
                .CW            (CW)
            ) u_counter (
                .clock (clock),
                .reset (reset),
                .inc   (issue_valid  & issue_oci[gi]),
                .dec_a (retire_valid & retire_oci[gi]),
                .dec_b (squash_valid & squash_oci[gi]),
                .count (in_flight_count[gi]),
                .error (counter_error[gi])
            );

            assign count_ext = CMP_W'(in_flight_count[gi]);
            assign free_ext  = CMP_W'(output_channel_free_slots[gi]);

`ifdef TIA_OUTPUT_CHANNEL_STRICT_PESSIMISM_EN
            assign updated_output_channel_full_status[gi] =
                (count_ext != '0) | (free_ext == '0);
`else
            // Full only when the writes already in flight could consume every free slot.
            assign updated_output_channel_full_status[gi] = (count_ext >= free_ext);
`endif

            assign issue_while_full[gi] =
                issue_valid & issue_oci[gi] & updated_output_channel_full_status[gi];
        end
    endgenerate

    assign protocol_error_next = protocol_error | (|counter_error) | (|issue_while_full);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            protocol_error <= 1'b0;
        end else begin
            protocol_error <= protocol_error_next;
        end
    end

endmodule
